apb_front_arbiter: RTL and testbench
====================================

Name: apb_front_arbiter

Overview:
- Shares the single front interface of the APB requester (transfer/write/addr/wdata in; rdata/ready out) among NUM_REQ internal masters.
- Round-robin arbitration: one grant per APB transaction.
- Sequences the requester: a one-cycle transfer pulse, then waits for APB completion.
- Returns read data and a done pulse to the granted master only.

Parameters:
- NUM_REQ, 4, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  per-master request; held until matching req_done.
- req_write  in  NUM_REQ  per-master write flag.
- req_addr  in  NUM_REQ*ADDR_W  per-master address, packed, master i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  per-master write data, packed.
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted master.
- req_rdata  out  DATA_W  read data; valid with req_done.
- m_transfer  out  1  to requester transfer.
- m_write  out  1  to requester write.
- m_addr  out  ADDR_W  to requester addr.
- m_wdata  out  DATA_W  to requester wdata.
- m_penable  in  1  tap of PENABLE.
- m_ready  in  1  requester ready (PREADY).
- m_rdata  in  DATA_W  requester rdata (PRDATA).
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant (debug).

Behaviour:
- Reset (PRESET=0, async): state=IDLE, rr_ptr=0, grant_id=0, m_transfer=0, m_write=0, m_addr=0, m_wdata=0, req_done=0, req_rdata=0.
- States:
  - IDLE: if any req_valid, pick the first valid index searching upward from rr_ptr, wrapping modulo NUM_REQ. Register grant_id, and latch write/addr/wdata of the winner into m_* registers. Go to ISSUE. No request: stay in IDLE, m_transfer=0.
  - ISSUE: m_transfer=1 for exactly this one cycle; m_* stable. Go to WAIT.
  - WAIT: m_transfer=0, m_* held. On m_penable & m_ready:
    - register m_rdata into req_rdata;
    - pulse req_done[grant_id] next cycle;
    - rr_ptr = grant_id+1, wrapping to 0 after NUM_REQ-1;
    - go to DONE.
    m_ready without m_penable is ignored (PREADY may idle high).
  - DONE: req_done pulse cycle. Go to IDLE; no arbitration in this cycle.
- Minimum transaction: grant cycle 0, transfer cycle 1, requester SETUP cycle 2, ACCESS cycle 3; with ready, req_done at cycle 4. A new grant is no earlier than cycle 5.
- Because m_transfer is never high while the requester is in ACCESS, the requester always returns to IDLE between transactions.
- Arbitration boundaries:
  - Simultaneous requests: the lowest index at or above rr_ptr wins.
  - Grant is fixed for the whole transaction; req_valid changes from other masters have no effect.
  - Granted master drops req_valid mid-transaction: the transaction still completes and req_done still pulses; the drop is not checked.
  - A master re-asserting immediately after done is served only after the other pending masters (fairness: at most NUM_REQ-1 transactions wait).
  - m_ready held low: WAIT indefinitely; no timeout.
- Reset mid-transaction: all outputs return to reset values immediately; no req_done is emitted.
- Unused m_wdata on reads is still driven from the latched value.

Optional Feature:
- Macro APB_ARB_LOCK_EN adds input port req_lock [NUM_REQ].
- Defined: if req_lock[grant_id] & req_valid[grant_id] is sampled in DONE, rr_ptr is not advanced and the same master is re-granted in the next IDLE. This gives atomic read-modify-write sequences.
- Not defined: the port is absent and the pointer always advances.

Decomposition:
- Package apb_arb_pkg: state enum arb_state_e {IDLE, ISSUE, WAIT, DONE}; constants ARB_ADDR_W=32, ARB_DATA_W=32.
- Sub-module apb_rr_pick: combinational rotate-priority picker.
  - Inputs: valid vector, pointer.
  - Outputs: any, index.
  - Instanced once.

Test Plan:
- Single read: master 2, addr 0x1000_1004, slave returns 0xDEADBEEF with PREADY in first ACCESS -> m_transfer high one cycle; req_done[2] 4 cycles after grant; req_rdata=0xDEADBEEF.
- All four masters request together from reset -> grant order 0,1,2,3; each req_done exactly once.
- Master 1 re-requests continuously while 3 is pending -> order 1,3,1,3.
- Wait states: PREADY low 3 ACCESS cycles, PREADY high while PENABLE=0 -> no early done; req_done after the 3 waits.
- PRESET asserted low during WAIT -> outputs zero asynchronously; after release, a pending master 0 is re-granted from rr_ptr=0.
- APB_ARB_LOCK_EN defined: master 3 locked, master 0 pending -> master 3 gets two consecutive grants, then master 0 once lock drops.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
//
// Purpose : shared types and constants for the APB front-end arbiter.
//           Provides the arbiter state encoding and the default address and
//           data widths used by apb_front_arbiter.
//
// Contents:
//   arb_state_e  - arbiter sequencing states (IDLE, ISSUE, WAIT, DONE)
//   ARB_ADDR_W   - default APB address width
//   ARB_DATA_W   - default APB data width
//   arb_next_idx - wrap-around successor of a master index
//
// Optional feature macro used by the arbiter: APB_ARB_LOCK_EN
// ---------------------------------------------------------------------------
package apb_arb_pkg;

    // Arbiter sequencing states. One pass IDLE->ISSUE->WAIT->DONE is one
    // APB transaction on behalf of one granted master.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    // Successor of a master index, wrapping to 0 after num_req-1. Works on a
    // 32-bit value so that it can serve every supported NUM_REQ; callers
    // truncate the result to their own pointer width.
    function automatic logic [31:0] arb_next_idx(input logic [31:0] idx,
                                                 input int num_req);
        logic [31:0] nxt;
        if (idx >= 32'(num_req - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + 32'd1;
        end
        return nxt;
    endfunction

endpackage : apb_arb_pkg

// File: rtl/apb_rr_pick.sv
// ---------------------------------------------------------------------------
// apb_rr_pick
//
// Purpose : combinational rotate-priority picker. Searches the request
//           vector upward starting at the round-robin pointer, wrapping
//           modulo NUM_REQ, and reports the first valid index found.
//
// Ports:
//   valid  in  [NUM_REQ-1:0]  request vector
//   ptr    in  [PTR_W-1:0]    index with the highest priority this round
//   any    out 1              at least one request is valid
//   index  out [PTR_W-1:0]    winning index (0 when any is low)
// ---------------------------------------------------------------------------
module apb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic               any,
    output logic [PTR_W-1:0]   index
);

    // Walk the candidates in priority order ptr, ptr+1, ... (mod NUM_REQ).
    // The sum is one bit wider than the pointer so that ptr+offset never
    // overflows before the modulo correction; a single subtraction is
    // enough because both operands are below NUM_REQ.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] cand;
        any   = 1'b0;
        index = '0;
        sum   = '0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(off);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
                sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (!any && valid[cand]) begin
                any   = 1'b1;
                index = cand;
            end
        end
    end

endmodule : apb_rr_pick

// File: rtl/apb_front_arbiter.sv
// ---------------------------------------------------------------------------
// apb_front_arbiter
//
// Purpose : shares the single front interface of an APB requester among
//           NUM_REQ internal masters. One master is granted per APB
//           transaction in round-robin order; the arbiter issues a one-cycle
//           transfer pulse, waits for the APB access phase to complete and
//           returns read data plus a one-cycle done pulse to that master.
//
// Parameters:
//   NUM_REQ  number of requesting masters (2..8)
//   ADDR_W   address width
//   DATA_W   data width
//
// Ports:
//   PCLK        in   clock
//   PRESET      in   asynchronous reset, active low
//   req_valid   in   [NUM_REQ]         per-master request, held until done
//   req_write   in   [NUM_REQ]         per-master write flag
//   req_addr    in   [NUM_REQ*ADDR_W]  packed addresses, master i at i*ADDR_W
//   req_wdata   in   [NUM_REQ*DATA_W]  packed write data
//   req_lock    in   [NUM_REQ]         keep grant on this master (macro only)
//   req_done    out  [NUM_REQ]         one-cycle completion pulse
//   req_rdata   out  [DATA_W]          read data, valid with req_done
//   m_transfer  out  1                 requester transfer strobe
//   m_write     out  1                 requester write
//   m_addr      out  [ADDR_W]          requester address
//   m_wdata     out  [DATA_W]          requester write data
//   m_penable   in   1                 tap of PENABLE
//   m_ready     in   1                 PREADY
//   m_rdata     in   [DATA_W]          PRDATA
//   grant_id    out  [$clog2(NUM_REQ)] current or last granted index
//
// Optional feature: define APB_ARB_LOCK_EN to add req_lock. A granted master
// holding both req_lock and req_valid when its transaction finishes keeps
// the round-robin pointer, so it is granted again next (atomic RMW).
// ---------------------------------------------------------------------------
module apb_front_arbiter
    import apb_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = ARB_ADDR_W,
    parameter  int DATA_W  = ARB_DATA_W,
    localparam int GID_W   = $clog2(NUM_REQ)
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef APB_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      m_transfer,
    output logic                      m_write,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic                      m_penable,
    input  logic                      m_ready,
    input  logic [DATA_W-1:0]         m_rdata,
    output logic [GID_W-1:0]          grant_id
);

    arb_state_e         state;
    logic [GID_W-1:0]   rr_ptr;
    logic               pick_any;
    logic [GID_W-1:0]   pick_idx;
    logic [GID_W-1:0]   next_ptr;
    logic               hold_ptr;
    logic               access_done;

    // Rotate-priority search over the live request vector. Only consulted
    // in IDLE, so request changes during a transaction cannot move the grant.
    apb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (GID_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .any   (pick_any),
        .index (pick_idx)
    );

    // Pointer value after serving grant_id: the master just above it, so
    // the master just served drops to lowest priority.
    assign next_ptr = GID_W'(arb_next_idx(32'(grant_id), NUM_REQ));

    // Completion needs the ACCESS phase: PREADY is allowed to idle high,
    // so ready alone during SETUP must not end the transaction.
    assign access_done = m_penable & m_ready;

    // Lock check for the master that just finished. Without the feature the
    // pointer always advances.
`ifdef APB_ARB_LOCK_EN
    assign hold_ptr = req_lock[grant_id] & req_valid[grant_id];
`else
    assign hold_ptr = 1'b0;
`endif

    // Transaction sequencer. Every output is registered here:
    //  - IDLE  latches the winner's command into m_* and raises m_transfer
    //          so that it is high during exactly the ISSUE cycle;
    //  - ISSUE drops m_transfer, the requester now runs SETUP/ACCESS;
    //  - WAIT  holds m_* until PENABLE&PREADY, captures PRDATA, arms the
    //          done pulse and advances the pointer past the granted master;
    //  - DONE  is the req_done cycle; no arbitration happens here, which
    //          keeps m_transfer low while the requester returns to IDLE.
    // In DONE a held lock puts the pointer back on the granted master.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            m_transfer <= 1'b0;
            m_write    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            req_done   <= '0;
            req_rdata  <= '0;
        end else begin
            req_done <= '0;
            case (state)
                IDLE: begin
                    m_transfer <= 1'b0;
                    if (pick_any) begin
                        grant_id   <= pick_idx;
                        m_write    <= req_write[pick_idx];
                        m_addr     <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        m_wdata    <= req_wdata[pick_idx*DATA_W +: DATA_W];
                        m_transfer <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_transfer <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    m_transfer <= 1'b0;
                    if (access_done) begin
                        req_rdata <= m_rdata;
                        req_done  <= NUM_REQ'(1) << grant_id;
                        rr_ptr    <= next_ptr;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    m_transfer <= 1'b0;
                    if (hold_ptr) begin
                        rr_ptr <= grant_id;
                    end
                    state <= IDLE;
                end
                default: begin
                    m_transfer <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule : apb_front_arbiter

// File: tb/tb_apb_front_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_front_arbiter
//
// Purpose : directed self-checking bench for apb_front_arbiter with four
//           masters. The bench plays the APB requester itself (SETUP cycle
//           after the transfer pulse, then ACCESS with PENABLE, optional
//           wait states) and compares against hand-computed grant order,
//           latched commands, read data and done pulses.
//
// Define APB_ARB_LOCK_EN for the bench and the design together to also run
// the lock sequence.
// ---------------------------------------------------------------------------
module tb_apb_front_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                      PCLK;
    logic                      PRESET;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
`ifdef APB_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif
    logic [NUM_REQ-1:0]        req_done;
    logic [DATA_W-1:0]         req_rdata;
    logic                      m_transfer;
    logic                      m_write;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic                      m_penable;
    logic                      m_ready;
    logic [DATA_W-1:0]         m_rdata;
    logic [1:0]                grant_id;

    int checks   = 0;
    int failures = 0;

    apb_front_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef APB_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .req_done   (req_done),
        .req_rdata  (req_rdata),
        .m_transfer (m_transfer),
        .m_write    (m_write),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_penable  (m_penable),
        .m_ready    (m_ready),
        .m_rdata    (m_rdata),
        .grant_id   (grant_id)
    );

    // Free-running clock, 10 time units per period. Inputs change and
    // outputs are sampled on the falling edge.
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Single comparison point: counts, asserts, reports on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h",
                   tag, observed, expected);
        end
    endtask

    // Drive the request fields of one master.
    task automatic applyStimulus(input int idx, input logic v, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        req_valid[idx]           = v;
        req_write[idx]           = w;
        req_addr[idx*32 +: 32]   = a;
        req_wdata[idx*32 +: 32]  = d;
    endtask

    // Wait (bounded) for the transfer pulse, then act as the APB requester
    // for one transaction: SETUP with PREADY at idle_ready, ACCESS with
    // 'waits' not-ready cycles, then check the done pulse and read data.
    // Returns at the falling edge after the done cycle.
    task automatic runTransaction(input logic [1:0] gid, input logic wr,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int waits,
                                  input logic idle_ready, input logic drop);
        int cnt;
        cnt = 0;
        while (m_transfer !== 1'b1 && cnt < 20) begin
            @(negedge PCLK);
            cnt++;
        end
        checkOutput("transfer_seen", 32'(m_transfer), 32'd1);
        checkOutput("grant_id", 32'(grant_id), 32'(gid));
        checkOutput("m_write", 32'(m_write), 32'(wr));
        checkOutput("m_addr", m_addr, addr);
        checkOutput("m_wdata", m_wdata, wdata);

        @(negedge PCLK);
        checkOutput("transfer_one_cycle", 32'(m_transfer), 32'd0);
        checkOutput("no_done_setup", 32'(req_done), 32'd0);
        m_penable = 1'b0;
        m_ready   = idle_ready;
        m_rdata   = 32'h5A5A_5A5A;
        if (drop) req_valid[gid] = 1'b0;

        @(negedge PCLK);
        checkOutput("no_done_setup_ready", 32'(req_done), 32'd0);
        m_penable = 1'b1;
        m_ready   = (waits == 0);
        m_rdata   = (waits == 0) ? rdata : 32'h5A5A_5A5A;

        for (int w = waits; w > 0; w--) begin
            @(negedge PCLK);
            checkOutput("no_done_wait", 32'(req_done), 32'd0);
            checkOutput("m_addr_held", m_addr, addr);
            if (w == 1) begin
                m_ready = 1'b1;
                m_rdata = rdata;
            end
        end

        @(negedge PCLK);
        checkOutput("req_done", 32'(req_done), 32'(4'(1) << gid));
        checkOutput("req_rdata", req_rdata, rdata);
        m_penable = 1'b0;
        m_ready   = idle_ready;
        m_rdata   = 32'h0;

        @(negedge PCLK);
        checkOutput("done_once", 32'(req_done), 32'd0);
        checkOutput("no_transfer_idle", 32'(m_transfer), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        int cnt;
        PRESET    = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef APB_ARB_LOCK_EN
        req_lock  = '0;
`endif
        m_penable = 1'b0;
        m_ready   = 1'b0;
        m_rdata   = '0;

        // Reset state.
        repeat (2) @(negedge PCLK);
        checkOutput("rst_transfer", 32'(m_transfer), 32'd0);
        checkOutput("rst_write", 32'(m_write), 32'd0);
        checkOutput("rst_addr", m_addr, 32'd0);
        checkOutput("rst_wdata", m_wdata, 32'd0);
        checkOutput("rst_done", 32'(req_done), 32'd0);
        checkOutput("rst_rdata", req_rdata, 32'd0);
        checkOutput("rst_grant", 32'(grant_id), 32'd0);
        PRESET = 1'b1;

        // All four request together: order 0,1,2,3.
        $display("[TB] all four masters from reset");
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 32'hA000_0000);
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0200, 32'hA111_1111);
        applyStimulus(2, 1'b1, 1'b0, 32'h0000_0300, 32'hA222_2222);
        applyStimulus(3, 1'b1, 1'b1, 32'h0000_0400, 32'hA333_3333);
        runTransaction(2'd0, 1'b0, 32'h0000_0100, 32'hA000_0000, 32'h1111_0000, 0, 1'b0, 1'b0);
        req_valid[0] = 1'b0;
        runTransaction(2'd1, 1'b1, 32'h0000_0200, 32'hA111_1111, 32'h1111_0001, 0, 1'b0, 1'b0);
        req_valid[1] = 1'b0;
        runTransaction(2'd2, 1'b0, 32'h0000_0300, 32'hA222_2222, 32'h1111_0002, 0, 1'b0, 1'b0);
        req_valid[2] = 1'b0;
        runTransaction(2'd3, 1'b1, 32'h0000_0400, 32'hA333_3333, 32'h1111_0003, 0, 1'b0, 1'b0);
        req_valid[3] = 1'b0;

        // Masters 1 and 3 keep requesting: pointer at 0 gives 1,3,1,3.
        $display("[TB] fairness between masters 1 and 3");
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_1110, 32'h0000_0001);
        applyStimulus(3, 1'b1, 1'b0, 32'h0000_3330, 32'h0000_0003);
        runTransaction(2'd1, 1'b0, 32'h0000_1110, 32'h0000_0001, 32'h2222_0001, 0, 1'b0, 1'b0);
        runTransaction(2'd3, 1'b0, 32'h0000_3330, 32'h0000_0003, 32'h2222_0003, 0, 1'b0, 1'b0);
        runTransaction(2'd1, 1'b0, 32'h0000_1110, 32'h0000_0001, 32'h2222_0011, 0, 1'b0, 1'b0);
        runTransaction(2'd3, 1'b0, 32'h0000_3330, 32'h0000_0003, 32'h2222_0033, 0, 1'b0, 1'b0);
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b0;

        // Single read from master 2, ready in the first ACCESS cycle.
        $display("[TB] single read master 2");
        applyStimulus(2, 1'b1, 1'b0, 32'h1000_1004, 32'h0000_0022);
        runTransaction(2'd2, 1'b0, 32'h1000_1004, 32'h0000_0022, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        req_valid[2] = 1'b0;

        // Write from master 1 with three wait states, PREADY idling high in
        // SETUP, and master 1 dropping its request mid-transaction.
        $display("[TB] wait states and early drop");
        applyStimulus(1, 1'b1, 1'b1, 32'h2000_0008, 32'hCAFE_F00D);
        runTransaction(2'd1, 1'b1, 32'h2000_0008, 32'hCAFE_F00D, 32'h7777_8888, 3, 1'b1, 1'b1);
        checkOutput("drop_valid_low", 32'(req_valid[1]), 32'd0);

        // Reset while stalled in WAIT; afterwards master 0 wins from ptr 0.
        $display("[TB] reset during WAIT");
        applyStimulus(3, 1'b1, 1'b0, 32'h3000_000C, 32'h0000_0333);
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0044);
        cnt = 0;
        while (m_transfer !== 1'b1 && cnt < 20) begin
            @(negedge PCLK);
            cnt++;
        end
        checkOutput("rstw_transfer_seen", 32'(m_transfer), 32'd1);
        checkOutput("rstw_grant", 32'(grant_id), 32'd3);
        @(negedge PCLK);
        m_penable = 1'b0;
        m_ready   = 1'b0;
        @(negedge PCLK);
        m_penable = 1'b1;
        @(negedge PCLK);
        checkOutput("rstw_stalled", 32'(req_done), 32'd0);
        checkOutput("rstw_addr_before", m_addr, 32'h3000_000C);
        #1 PRESET = 1'b0;
        #1;
        checkOutput("rstw_async_addr", m_addr, 32'd0);
        checkOutput("rstw_async_wdata", m_wdata, 32'd0);
        checkOutput("rstw_async_grant", 32'(grant_id), 32'd0);
        checkOutput("rstw_async_rdata", req_rdata, 32'd0);
        checkOutput("rstw_async_transfer", 32'(m_transfer), 32'd0);
        m_penable = 1'b0;
        @(negedge PCLK);
        checkOutput("rstw_no_done", 32'(req_done), 32'd0);
        PRESET = 1'b1;
        runTransaction(2'd0, 1'b0, 32'h0000_0040, 32'h0000_0044, 32'h0000_ABCD, 0, 1'b0, 1'b0);
        req_valid[0] = 1'b0;
        req_valid[3] = 1'b0;

`ifdef APB_ARB_LOCK_EN
        // Locked master 3 gets two grants in a row, then master 0.
        $display("[TB] lock sequence");
        repeat (2) @(negedge PCLK);
        applyStimulus(3, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_0000);
        req_lock[3] = 1'b1;
        @(negedge PCLK);
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0055);
        runTransaction(2'd3, 1'b0, 32'h0000_3000, 32'h0000_0000, 32'h0000_0010, 0, 1'b0, 1'b0);
        applyStimulus(3, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_0011);
        runTransaction(2'd3, 1'b1, 32'h0000_3000, 32'h0000_0011, 32'h0000_0000, 0, 1'b0, 1'b1);
        req_lock[3] = 1'b0;
        runTransaction(2'd0, 1'b1, 32'h0000_0500, 32'h0000_0055, 32'h0000_0000, 0, 1'b0, 1'b0);
        req_valid[0] = 1'b0;
`endif

        repeat (2) @(negedge PCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_apb_front_arbiter
